// File: rtl/cnn_pkg.sv
// Shared CNN fixed-point types, constants and the output saturation/ReLU helper.
package cnn_pkg;

    localparam int DW    = 16;
    localparam int FRAC  = 8;
    localparam int ACC_W = 40;
    localparam int TAPS  = 25;
    localparam int N_CH  = 3;
    localparam int CNT_W = $clog2(TAPS + 1);

    typedef logic signed [DW-1:0]   data_t;
    typedef logic signed [2*DW-1:0] prod_t;
    typedef logic signed [ACC_W-1:0] acc_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LEAD = 2'd1,
        ACC  = 2'd2
    } conv_state_t;

    // Clamp a rescaled accumulator value into the data range, then optionally drop negatives.
    function automatic data_t sat_relu(input acc_t v, input logic relu_en);
        acc_t  max_v;
        acc_t  min_v;
        data_t r;
        max_v = acc_t'((2 ** (DW - 1)) - 1);
        min_v = -acc_t'(2 ** (DW - 1));
        if (v > max_v) begin
            r = {1'b0, {(DW-1){1'b1}}};
        end else if (v < min_v) begin
            r = {1'b1, {(DW-1){1'b0}}};
        end else begin
            r = v[DW-1:0];
        end
        if (relu_en && r[DW-1]) begin
            r = '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/conv1_mac_lane.sv
// One output channel of the conv1 MAC: multiply stage, window accumulator and
// bias/rescale/saturate output stage. Stage timing comes from tags held in the top.
module conv1_mac_lane
    import cnn_pkg::*;
#(
    parameter bit RELU_EN = 1'b1
) (
    input  logic  clk,
    input  logic  n_reset,
    input  logic  i_s1_en,     // a window tap is sampled this cycle
    input  data_t i_pix,
    input  data_t i_weight,
    input  data_t i_bias,
    input  logic  i_s2_en,     // S1 holds a valid product
    input  logic  i_s2_first,  // S1 product is tap 1 of its window
    input  logic  i_s3_en,     // S2 holds the completed window sum
    output data_t o_fmap
);

    prod_t r_prod;
    acc_t  r_acc;
    data_t r_fmap;
    acc_t  w_round;
    acc_t  w_scaled;

    // Bias is aligned to the accumulator's Q format; adding half an LSB before the
    // arithmetic shift gives round-half-up.
    always_comb begin
        w_round  = r_acc + (acc_t'(i_bias) <<< FRAC) + (acc_t'(1) <<< (FRAC - 1));
        w_scaled = w_round >>> FRAC;
    end

    // S1: full-precision product of the sampled tap.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_prod <= '0;
        end else if (i_s1_en) begin
            r_prod <= prod_t'(i_pix) * prod_t'(i_weight);
        end
    end

    // S2: window accumulator, restarted by the first tap so partial sums never leak.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_acc <= '0;
        end else if (i_s2_en) begin
            r_acc <= i_s2_first ? acc_t'(r_prod) : r_acc + acc_t'(r_prod);
        end
    end

    // S3: capture the finished sample; it holds until the next window completes.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_fmap <= '0;
        end else if (i_s3_en) begin
            r_fmap <= sat_relu(w_scaled, RELU_EN);
        end
    end

    assign o_fmap = r_fmap;

endmodule

// File: rtl/conv1_mac_engine.sv
// conv1 MAC engine: consumes the streamed 5x5 weight taps with aligned pixels and
// emits one saturated, ReLU'd 3-channel feature-map sample per window.
// Handshake: no back-pressure. start=1 means a tap arrives every cycle (one lead-in,
// then back-to-back windows); out_valid is a single-cycle pulse qualifying fmap_out
// and out_idx, which hold their values until the next pulse.
module conv1_mac_engine
    import cnn_pkg::*;
#(
    parameter bit RELU_EN = 1'b1,
    parameter int IDX_W   = 10
) (
    input  logic                    clk,
    input  logic                    n_reset,
    input  logic                    start,
    input  logic [DW-1:0]           pix_in,
    input  logic [N_CH:1][DW-1:0]   weight_conv1,
    input  logic [N_CH:1][DW-1:0]   bias_conv1,
    output logic [N_CH:1][DW-1:0]   fmap_out,
    output logic                    out_valid,
    output logic [IDX_W-1:0]        out_idx,
    output logic                    busy,
    output conv_state_t             o_dbg_state
);

    conv_state_t      r_state;
    logic [CNT_W-1:0] r_tap_cnt;
    logic             r_s1_valid;
    logic             r_s1_first;
    logic             r_s1_last;
    logic             r_s2_last;
    logic             r_out_valid;
    logic [IDX_W-1:0] r_out_idx;
    logic [IDX_W-1:0] r_win_cnt;
    logic             w_tap_en;

    // Only taps sampled in ACC with start still high belong to a window.
    assign w_tap_en = (r_state == ACC) && start;

    // Stream FSM and tap position; dropping start discards any partial window.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state   <= IDLE;
            r_tap_cnt <= '0;
        end else if (!start) begin
            r_state   <= IDLE;
            r_tap_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= LEAD;
                end
                LEAD: begin
                    r_state   <= ACC;
                    r_tap_cnt <= CNT_W'(1);
                end
                ACC: begin
                    r_tap_cnt <= (r_tap_cnt == CNT_W'(TAPS)) ? CNT_W'(1) : r_tap_cnt + CNT_W'(1);
                end
                default: begin
                    r_state   <= IDLE;
                    r_tap_cnt <= '0;
                end
            endcase
        end
    end

    // Stage tags travel alongside the lane data so a draining window is independent of the FSM.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_s1_valid <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s2_last  <= 1'b0;
        end else begin
            r_s1_valid <= w_tap_en;
            r_s1_first <= w_tap_en && (r_tap_cnt == CNT_W'(1));
            r_s1_last  <= w_tap_en && (r_tap_cnt == CNT_W'(TAPS));
            r_s2_last  <= r_s1_valid && r_s1_last;
        end
    end

    // Output pulse, window index and window counter; a fresh run from IDLE restarts
    // numbering, taking priority over the increment of a window draining that cycle.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
            r_win_cnt   <= '0;
        end else begin
            r_out_valid <= r_s2_last;
            if (r_s2_last) begin
                r_out_idx <= r_win_cnt;
            end
            if ((r_state == IDLE) && start) begin
                r_win_cnt <= '0;
            end else if (r_s2_last) begin
                r_win_cnt <= r_win_cnt + IDX_W'(1);
            end
        end
    end

    for (genvar g = 1; g <= N_CH; g++) begin : g_lane
        conv1_mac_lane #(
            .RELU_EN (RELU_EN)
        ) u_lane (
            .clk        (clk),
            .n_reset    (n_reset),
            .i_s1_en    (w_tap_en),
            .i_pix      (pix_in),
            .i_weight   (weight_conv1[g]),
            .i_bias     (bias_conv1[g]),
            .i_s2_en    (r_s1_valid),
            .i_s2_first (r_s1_first),
            .i_s3_en    (r_s2_last),
            .o_fmap     (fmap_out[g])
        );
    end

    assign out_valid   = r_out_valid;
    assign out_idx     = r_out_idx;
    assign busy        = (r_state != IDLE) || r_s1_last || r_s2_last;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_conv1_mac_engine.sv
// Directed bench for conv1_mac_engine: a ReLU and a non-ReLU instance share all inputs.
module tb_conv1_mac_engine;
    import cnn_pkg::*;

    logic                  clk = 1'b0;
    logic                  n_reset;
    logic                  start;
    logic [DW-1:0]         pix_in;
    logic [N_CH:1][DW-1:0] weight_conv1;
    logic [N_CH:1][DW-1:0] bias_conv1;
    logic [N_CH:1][DW-1:0] fmap_out, fmap_out_nr;
    logic                  out_valid, out_valid_nr;
    logic [9:0]            out_idx, out_idx_nr;
    logic                  busy, busy_nr;
    conv_state_t           dbg_state, dbg_state_nr;

    conv1_mac_engine #(.RELU_EN(1'b1), .IDX_W(10)) dut (
        .clk(clk), .n_reset(n_reset), .start(start), .pix_in(pix_in),
        .weight_conv1(weight_conv1), .bias_conv1(bias_conv1), .fmap_out(fmap_out),
        .out_valid(out_valid), .out_idx(out_idx), .busy(busy), .o_dbg_state(dbg_state)
    );

    conv1_mac_engine #(.RELU_EN(1'b0), .IDX_W(10)) dut_nr (
        .clk(clk), .n_reset(n_reset), .start(start), .pix_in(pix_in),
        .weight_conv1(weight_conv1), .bias_conv1(bias_conv1), .fmap_out(fmap_out_nr),
        .out_valid(out_valid_nr), .out_idx(out_idx_nr), .busy(busy_nr), .o_dbg_state(dbg_state_nr)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [N_CH:1][DW-1:0] f;
        logic [N_CH:1][DW-1:0] fnr;
        logic [9:0]            idx;
        logic [31:0]           cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Every pulse must match the oldest expectation in value, index and arrival cycle.
    always @(negedge clk) begin
        if (out_valid || out_valid_nr) begin
            check("valid_align", 64'(out_valid_nr), 64'(out_valid));
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_pulse: out_idx=%0d at cycle %0d, none expected", out_idx, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("fmap_relu",  64'(fmap_out),    64'(mon_e.f));
                check("fmap_norelu", 64'(fmap_out_nr), 64'(mon_e.fnr));
                check("out_idx",    64'(out_idx),     64'(mon_e.idx));
                check("pulse_cycle", 64'(cyc),        64'(mon_e.cyc));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Raise start; the cycle after the IDLE->LEAD edge presents the zero lead-in tap.
    task automatic start_session(input logic [N_CH:1][DW-1:0] b);
        @(negedge clk);
        bias_conv1   = b;
        start        = 1'b1;
        pix_in       = '0;
        weight_conv1 = '0;
        @(negedge clk);
        check("lead_state", 64'(dbg_state), 64'(LEAD));
        check("lead_busy",  64'(busy),      64'd1);
    endtask

    // Present TAPS identical taps; the result is due 3 cycles after the last one is presented.
    task automatic drive_window(input logic [DW-1:0] p, input logic [N_CH:1][DW-1:0] w,
                                input logic [N_CH:1][DW-1:0] e, input logic [N_CH:1][DW-1:0] enr,
                                input logic [9:0] idx);
        exp_t x;
        for (int t = 1; t <= TAPS; t++) begin
            @(negedge clk);
            pix_in       = p;
            weight_conv1 = w;
        end
        x.f   = e;
        x.fnr = enr;
        x.idx = idx;
        x.cyc = 32'(cyc + 3);
        exp_q.push_back(x);
    endtask

    // Drop start right after the last tap was sampled and watch the window drain.
    task automatic stop_after_window();
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("drain_state", 64'(dbg_state), 64'(IDLE));
        check("drain_busy",  64'(busy),      64'd1);
        @(negedge clk);
        check("done_busy",   64'(busy),      64'd0);
        repeat (3) @(negedge clk);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [DW-1:0]         pix;
        logic [N_CH:1][DW-1:0] w;
        logic [N_CH:1][DW-1:0] b;
        logic [N_CH:1][DW-1:0] exp;
        logic [N_CH:1][DW-1:0] exp_nr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        // unity taps: 25 x 1.0 = 25.0
        vecs[0] = '{16'h0100, {16'h0100, 16'h0100, 16'h0100}, {16'h0000, 16'h0000, 16'h0000},
                    {16'h1900, 16'h1900, 16'h1900}, {16'h1900, 16'h1900, 16'h1900}};
        // per-channel bias +1.0 / -1.0 / 0
        vecs[1] = '{16'h0100, {16'h0100, 16'h0100, 16'h0100}, {16'h0100, 16'hFF00, 16'h0000},
                    {16'h1A00, 16'h1800, 16'h1900}, {16'h1A00, 16'h1800, 16'h1900}};
        // -25.0: clamped by ReLU
        vecs[2] = '{16'h0100, {16'hFF00, 16'hFF00, 16'hFF00}, {16'h0000, 16'h0000, 16'h0000},
                    {16'h0000, 16'h0000, 16'h0000}, {16'hE700, 16'hE700, 16'hE700}};
        // positive saturation
        vecs[3] = '{16'h7FFF, {16'h7FFF, 16'h7FFF, 16'h7FFF}, {16'h0000, 16'h0000, 16'h0000},
                    {16'h7FFF, 16'h7FFF, 16'h7FFF}, {16'h7FFF, 16'h7FFF, 16'h7FFF}};
        // 12.5 / -3.125+2.0=-1.125 / 36.5/256 rounds up to 37 LSB
        vecs[4] = '{16'h0080, {16'h0100, 16'hFFC0, 16'h0003}, {16'h0000, 16'h0200, 16'hFFFF},
                    {16'h0C80, 16'h0000, 16'h0025}, {16'h0C80, 16'hFEE0, 16'h0025}};
        // negative saturation / positive saturation / exact max via bias only
        vecs[5] = '{16'h7FFF, {16'h8000, 16'h7FFF, 16'h0000}, {16'h0000, 16'h0000, 16'h7FFF},
                    {16'h0000, 16'h7FFF, 16'h7FFF}, {16'h8000, 16'h7FFF, 16'h7FFF}};
    end

    // ---------------- test sequence ----------------
    initial begin
        n_reset      = 1'b0;
        start        = 1'b0;
        pix_in       = '0;
        weight_conv1 = '0;
        bias_conv1   = '0;
        repeat (3) @(negedge clk);
        check("rst_fmap",   64'(fmap_out),  64'd0);
        check("rst_valid",  64'(out_valid), 64'd0);
        check("rst_idx",    64'(out_idx),   64'd0);
        check("rst_busy",   64'(busy),      64'd0);
        check("rst_state",  64'(dbg_state), 64'(IDLE));
        n_reset = 1'b1;
        repeat (2) @(negedge clk);

        // single-window sessions from the table
        for (int v = 0; v < 6; v++) begin
            start_session(vecs[v].b);
            drive_window(vecs[v].pix, vecs[v].w, vecs[v].exp, vecs[v].exp_nr, 10'd0);
            stop_after_window();
        end

        // three back-to-back windows, each restarting the accumulator
        start_session('0);
        drive_window(16'h0100, {3{16'h0100}}, {3{16'h1900}}, {3{16'h1900}}, 10'd0);
        drive_window(16'h0100, {3{16'hFF00}}, {3{16'h0000}}, {3{16'hE700}}, 10'd1);
        drive_window(16'h0100, {3{16'h0200}}, {3{16'h3200}}, {3{16'h3200}}, 10'd2);
        stop_after_window();
        check("fmap_hold", 64'(fmap_out), 64'({3{16'h3200}}));
        check("idx_hold",  64'(out_idx),  64'd2);

        // asynchronous reset in the middle of a window
        start_session('0);
        for (int t = 1; t <= 19; t++) begin
            @(negedge clk);
            pix_in       = 16'h0100;
            weight_conv1 = {3{16'h0100}};
        end
        @(negedge clk);
        n_reset = 1'b0;
        #1;
        check("arst_fmap",    64'(fmap_out),    64'd0);
        check("arst_fmap_nr", 64'(fmap_out_nr), 64'd0);
        check("arst_valid",   64'(out_valid),   64'd0);
        check("arst_idx",     64'(out_idx),     64'd0);
        check("arst_busy",    64'(busy),        64'd0);
        check("arst_state",   64'(dbg_state),   64'(IDLE));
        repeat (2) @(negedge clk);
        start   = 1'b0;
        n_reset = 1'b1;
        repeat (30) @(negedge clk);

        // abort at tap 10, idle 4 cycles, then a clean window
        start_session('0);
        for (int t = 1; t <= 10; t++) begin
            @(negedge clk);
            pix_in       = 16'h0100;
            weight_conv1 = {3{16'h0300}};
        end
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("abort_state", 64'(dbg_state), 64'(IDLE));
        check("abort_busy",  64'(busy),      64'd0);
        repeat (2) @(negedge clk);
        start_session('0);
        drive_window(16'h0100, {3{16'h0100}}, {3{16'h1900}}, {3{16'h1900}}, 10'd0);
        stop_after_window();

        // restart while window 1 drains: drained pulse keeps idx 1, new run counts from 0
        start_session('0);
        drive_window(16'h0100, {3{16'h0100}}, {3{16'h1900}}, {3{16'h1900}}, 10'd0);
        drive_window(16'h0100, {3{16'h0200}}, {3{16'h3200}}, {3{16'h3200}}, 10'd1);
        @(negedge clk);
        start = 1'b0;
        start_session('0);
        drive_window(16'h0100, {3{16'hFF00}}, {3{16'h0000}}, {3{16'hE700}}, 10'd0);
        stop_after_window();

        // every expected pulse must have arrived
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        check("pending_pulses", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
